tl_conflict_monitor: RTL and testbench

- Independent checker that reads the six lamp outputs of the two-direction traffic light controller, plus its two emergency inputs.
- Flags illegal lamp states, conflicting greens, illegal colour sequences and timing violations.
- Latches the first fault and drives a flashing-red enable so the lamps can be overridden to a safe state.
- Sits beside the controller on the same clock and has no feedback into the controller's FSM.

---
 rtl/tl_pkg.sv | 49 ++++
 rtl/tl_lamp_tracker.sv | 82 ++++++++
 rtl/tl_conflict_monitor.sv | 193 +++++++++++++++++++
 tb/tb_tl_conflict_monitor.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared types and helpers for the traffic-light conflict monitor.
package tl_pkg;

  // Per-direction lamp state as seen by the monitor.
  typedef enum logic [1:0] {
    L_RED = 2'd0,
    L_YEL = 2'd1,
    L_GRN = 2'd2,
    L_ILL = 2'd3
  } lamp_t;

  // Fault codes; a lower value wins when several faults hit in one cycle.
  typedef enum logic [2:0] {
    F_NONE        = 3'd0,
    F_LAMP        = 3'd1,
    F_CONFLICT    = 3'd2,
    F_SEQ         = 3'd3,
    F_SHORT_GREEN = 3'd4,
    F_YELLOW      = 3'd5
  } fault_code_t;

  localparam int unsigned DIR_W = 2;

  // Result of one cycle's priority encode.
  typedef struct packed {
    fault_code_t        code;
    logic [DIR_W-1:0]   dir;
  } fault_rpt_t;

  // One-hot {R,Y,G} to lamp state; anything else is illegal.
  function automatic lamp_t lamp_decode(input logic r, input logic y, input logic g);
    lamp_t l;
    case ({r, y, g})
      3'b100:  l = L_RED;
      3'b010:  l = L_YEL;
      3'b001:  l = L_GRN;
      default: l = L_ILL;
    endcase
    return l;
  endfunction

  // Steps that skip a colour of the G->Y->R->G cycle.
  function automatic logic illegal_step(input lamp_t prev, input lamp_t cur);
    return ((prev == L_GRN) && (cur == L_RED)) ||
           ((prev == L_YEL) && (cur == L_GRN)) ||
           ((prev == L_RED) && (cur == L_YEL));
  endfunction

endpackage

// File: rtl/tl_lamp_tracker.sv
// Per-direction lamp history: tracks the current lamp interval and flags
// illegal lamp patterns, illegal colour steps and interval timing errors.
module tl_lamp_tracker
  import tl_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned YELLOW_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r_i,
  input  logic             y_i,
  input  logic             g_i,
  input  logic             emg_q_i,
  input  logic             warm_i,
  input  logic [CNT_W-1:0] min_green_i,
  output lamp_t            lamp_c_o,
  output logic             lamp_err_c_o,
  output logic             seq_err_c_o,
  output logic             short_green_c_o,
  output logic             yellow_err_c_o
);

  localparam logic [CNT_W-1:0] DUR_MAX = '1;
  localparam logic [CNT_W-1:0] DUR_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] YEL_DUR = CNT_W'(YELLOW_CYC);

  lamp_t            prev_q, prev_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic             emg_seen_q, emg_seen_d;
  logic             valid_q, valid_d;

  lamp_t            cur_c;
  logic             hist_c;
  logic             leave_c;
  logic             relaxed_c;

  // Checks against the stored interval, plus next interval state.
  always_comb begin
    cur_c      = lamp_decode(r_i, y_i, g_i);
    hist_c     = valid_q && !warm_i && (cur_c != L_ILL);
    leave_c    = hist_c && (cur_c != prev_q);
    // emg_q in the leaving cycle is the emergency seen in the interval's last cycle
    relaxed_c  = emg_seen_q || emg_q_i;

    lamp_err_c_o    = (cur_c == L_ILL);
    seq_err_c_o     = leave_c && !emg_q_i && illegal_step(prev_q, cur_c);
    short_green_c_o = leave_c && (prev_q == L_GRN) && (dur_q < min_green_i) && !relaxed_c;
    yellow_err_c_o  = leave_c && (prev_q == L_YEL) && (dur_q != YEL_DUR) && !relaxed_c;
    lamp_c_o        = cur_c;

    prev_d     = cur_c;
    dur_d      = DUR_ONE;
    emg_seen_d = 1'b0;
    valid_d    = 1'b1;
    if (cur_c == L_ILL) begin
      // illegal pattern: forget history, next legal lamp starts fresh
      prev_d  = L_RED;
      dur_d   = '0;
      valid_d = 1'b0;
    end else if (hist_c && (cur_c == prev_q)) begin
      dur_d      = (dur_q == DUR_MAX) ? dur_q : dur_q + DUR_ONE;
      emg_seen_d = emg_seen_q || emg_q_i;
    end
  end

  // Interval state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= L_RED;
      dur_q      <= '0;
      emg_seen_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      dur_q      <= dur_d;
      emg_seen_q <= emg_seen_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: rtl/tl_conflict_monitor.sv
// Independent safety monitor for the two-direction traffic light controller:
// detects lamp, conflict, sequence and timing faults, latches the first one
// and produces a flashing-red enable while a fault is held.
module tl_conflict_monitor
  import tl_pkg::*;
#(
  parameter int unsigned MIN_GREEN_A = 6,
  parameter int unsigned MIN_GREEN_B = 5,
  parameter int unsigned YELLOW_CYC  = 1,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned FLASH_DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RA,
  input  logic             YA,
  input  logic             GA,
  input  logic             RB,
  input  logic             YB,
  input  logic             GB,
  input  logic             Emg_A,
  input  logic             Emg_B,
  input  logic             clr_fault,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [1:0]       fault_dir,
  output logic [CNT_W-1:0] fault_cnt,
  output logic             flash
);

  localparam int unsigned      DIV_W    = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FLASH_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_G_A  = CNT_W'(MIN_GREEN_A);
  localparam logic [CNT_W-1:0] MIN_G_B  = CNT_W'(MIN_GREEN_B);

  logic             warm_q, warm_d;
  logic             emg_q, emg_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic [1:0]       dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flash_q, flash_d;
  logic [DIV_W-1:0] div_q, div_d;

  lamp_t      lamp_a_c, lamp_b_c;
  logic       lerr_a_c, lerr_b_c;
  logic       seq_a_c, seq_b_c;
  logic       short_a_c, short_b_c;
  logic       yel_a_c, yel_b_c;
  logic       go_a_c, go_b_c;
  logic       conflict_c;
  logic       any_fault_c;
  fault_rpt_t rpt_c;

  tl_lamp_tracker #(
    .CNT_W      (CNT_W),
    .YELLOW_CYC (YELLOW_CYC)
  ) u_trk_a (
    .clk             (clk),
    .rst_n           (rst_n),
    .r_i             (RA),
    .y_i             (YA),
    .g_i             (GA),
    .emg_q_i         (emg_q),
    .warm_i          (warm_q),
    .min_green_i     (MIN_G_A),
    .lamp_c_o        (lamp_a_c),
    .lamp_err_c_o    (lerr_a_c),
    .seq_err_c_o     (seq_a_c),
    .short_green_c_o (short_a_c),
    .yellow_err_c_o  (yel_a_c)
  );

  tl_lamp_tracker #(
    .CNT_W      (CNT_W),
    .YELLOW_CYC (YELLOW_CYC)
  ) u_trk_b (
    .clk             (clk),
    .rst_n           (rst_n),
    .r_i             (RB),
    .y_i             (YB),
    .g_i             (GB),
    .emg_q_i         (emg_q),
    .warm_i          (warm_q),
    .min_green_i     (MIN_G_B),
    .lamp_c_o        (lamp_b_c),
    .lamp_err_c_o    (lerr_b_c),
    .seq_err_c_o     (seq_b_c),
    .short_green_c_o (short_b_c),
    .yellow_err_c_o  (yel_b_c)
  );

  // Conflict and priority encode of this cycle's faults.
  always_comb begin
    // decoded lamps suffice: a pattern that is not one-hot is already a
    // higher-priority LAMP fault, so it never needs to report as CONFLICT
    go_a_c     = (lamp_a_c == L_GRN) || (lamp_a_c == L_YEL);
    go_b_c     = (lamp_b_c == L_GRN) || (lamp_b_c == L_YEL);
    conflict_c = go_a_c && go_b_c;

    rpt_c.code = F_NONE;
    rpt_c.dir  = 2'b00;
    if (lerr_a_c || lerr_b_c) begin
      rpt_c.code = F_LAMP;
      rpt_c.dir  = {lerr_b_c, lerr_a_c};
    end else if (conflict_c) begin
      rpt_c.code = F_CONFLICT;
      rpt_c.dir  = 2'b11;
    end else if (seq_a_c || seq_b_c) begin
      rpt_c.code = F_SEQ;
      rpt_c.dir  = {seq_b_c, seq_a_c};
    end else if (short_a_c || short_b_c) begin
      rpt_c.code = F_SHORT_GREEN;
      rpt_c.dir  = {short_b_c, short_a_c};
    end else if (yel_a_c || yel_b_c) begin
      rpt_c.code = F_YELLOW;
      rpt_c.dir  = {yel_b_c, yel_a_c};
    end
    any_fault_c = (rpt_c.code != F_NONE);
  end

  // Fault latch, saturating fault counter and flash divider.
  always_comb begin
    warm_d  = 1'b0;
    emg_d   = Emg_A || Emg_B;
    fault_d = fault_q;
    code_d  = code_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    flash_d = flash_q;
    div_d   = div_q;

    if (any_fault_c && (!fault_q || clr_fault)) begin
      fault_d = 1'b1;
      code_d  = rpt_c.code;
      dir_d   = rpt_c.dir;
    end else if (clr_fault) begin
      fault_d = 1'b0;
      code_d  = F_NONE;
      dir_d   = 2'b00;
    end

    if (any_fault_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (!fault_d) begin
      flash_d = 1'b0;
      div_d   = '0;
    end else if (!fault_q) begin
      flash_d = 1'b1;
      div_d   = '0;
    end else if (div_q == DIV_LAST) begin
      flash_d = !flash_q;
      div_d   = '0;
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q  <= 1'b1;
      emg_q   <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= F_NONE;
      dir_q   <= 2'b00;
      cnt_q   <= '0;
      flash_q <= 1'b0;
      div_q   <= '0;
    end else begin
      warm_q  <= warm_d;
      emg_q   <= emg_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
      div_q   <= div_d;
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign fault_dir  = dir_q;
  assign fault_cnt  = cnt_q;
  assign flash      = flash_q;

endmodule

// File: tb/tb_tl_conflict_monitor.sv
// Self-checking bench for tl_conflict_monitor: directed scenarios against
// fixed expectations plus randomized lamp traffic against an interval model.
module tb_tl_conflict_monitor;

  localparam int MIN_GA  = 6;
  localparam int MIN_GB  = 5;
  localparam int YEL     = 1;
  localparam int FDIV    = 4;
  localparam int CNT_MAX = 255;
  localparam logic [2:0] C_R  = 3'b100;
  localparam logic [2:0] C_Y  = 3'b010;
  localparam logic [2:0] C_G  = 3'b001;
  localparam logic [2:0] C_RY = 3'b110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RA = 1'b1, YA = 1'b0, GA = 1'b0;
  logic       RB = 1'b1, YB = 1'b0, GB = 1'b0;
  logic       Emg_A = 1'b0, Emg_B = 1'b0, clr_fault = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_dir;
  logic [7:0] fault_cnt;
  logic       flash;

  int total = 0;
  int bad   = 0;

  // reference model: latch state plus one record per direction describing
  // the lamp interval currently in progress
  bit m_fault;
  int m_code, m_dir, m_cnt, m_age;
  int m_last [2];
  int m_len  [2];
  bit m_emg  [2];
  bit m_valid[2];
  bit m_prev_emg;

  tl_conflict_monitor #(
    .MIN_GREEN_A (MIN_GA),
    .MIN_GREEN_B (MIN_GB),
    .YELLOW_CYC  (YEL),
    .CNT_W       (8),
    .FLASH_DIV   (FDIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RA         (RA),
    .YA         (YA),
    .GA         (GA),
    .RB         (RB),
    .YB         (YB),
    .GB         (GB),
    .Emg_A      (Emg_A),
    .Emg_B      (Emg_B),
    .clr_fault  (clr_fault),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_dir  (fault_dir),
    .fault_cnt  (fault_cnt),
    .flash      (flash)
  );

  always #5 clk = ~clk;

  // 0=R 1=Y 2=G 3=not one-hot
  function automatic int colour(input logic [2:0] p);
    if (p == C_R) return 0;
    if (p == C_Y) return 1;
    if (p == C_G) return 2;
    return 3;
  endfunction

  // the colour that must follow c in the G->Y->R->G cycle
  function automatic int succ(input int c);
    return (c == 0) ? 2 : c - 1;
  endfunction

  function automatic bit m_flash();
    return m_fault && (((m_age / FDIV) % 2) == 0);
  endfunction

  task automatic model_reset();
    m_fault = 0; m_code = 0; m_dir = 0; m_cnt = 0; m_age = 0;
    m_prev_emg = 0;
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 0; m_len[d] = 0; m_emg[d] = 0; m_valid[d] = 0;
    end
  endtask

  task automatic model_step(input logic [2:0] a, input logic [2:0] b,
                            input bit e, input bit clr);
    int  c[2];
    bit  lerr[2], serr[2], sh[2], ye[2];
    bit  conflict;
    int  code, dir;
    c[0] = colour(a);
    c[1] = colour(b);
    for (int d = 0; d < 2; d++) begin
      lerr[d] = (c[d] == 3);
      serr[d] = 0; sh[d] = 0; ye[d] = 0;
      if (!lerr[d] && m_valid[d] && c[d] != m_last[d]) begin
        serr[d] = !m_prev_emg && (c[d] != succ(m_last[d]));
        sh[d]   = (m_last[d] == 2) && (m_len[d] < ((d == 0) ? MIN_GA : MIN_GB)) && !m_emg[d];
        ye[d]   = (m_last[d] == 1) && (m_len[d] != YEL) && !m_emg[d];
      end
    end
    conflict = (a[1] | a[0]) & (b[1] | b[0]);
    code = 0; dir = 0;
    if (lerr[0] || lerr[1])    begin code = 1; dir = int'(lerr[0]) + 2 * int'(lerr[1]); end
    else if (conflict)         begin code = 2; dir = 3; end
    else if (serr[0] || serr[1]) begin code = 3; dir = int'(serr[0]) + 2 * int'(serr[1]); end
    else if (sh[0] || sh[1])   begin code = 4; dir = int'(sh[0]) + 2 * int'(sh[1]); end
    else if (ye[0] || ye[1])   begin code = 5; dir = int'(ye[0]) + 2 * int'(ye[1]); end

    for (int d = 0; d < 2; d++) begin
      if (c[d] == 3) begin
        m_valid[d] = 0;
      end else if (m_valid[d] && c[d] == m_last[d]) begin
        m_len[d] = (m_len[d] < CNT_MAX) ? m_len[d] + 1 : CNT_MAX;
        m_emg[d] = m_emg[d] | e;
      end else begin
        m_last[d] = c[d]; m_len[d] = 1; m_emg[d] = e; m_valid[d] = 1;
      end
    end
    m_prev_emg = e;

    if (code != 0 && (!m_fault || clr)) begin
      m_age   = m_fault ? m_age + 1 : 0;
      m_fault = 1; m_code = code; m_dir = dir;
    end else if (clr) begin
      m_fault = 0; m_code = 0; m_dir = 0; m_age = 0;
    end else if (m_fault) begin
      m_age = m_age + 1;
    end
    if (code != 0) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
  endtask

  // drive one cycle at the falling edge, return 1 time unit after the rising edge
  task automatic cycle(input logic [2:0] a, input logic [2:0] b,
                       input logic ea, input logic eb, input logic clr);
    @(negedge clk);
    {RA, YA, GA} = a;
    {RB, YB, GB} = b;
    Emg_A = ea; Emg_B = eb; clr_fault = clr;
    model_step(a, b, ea | eb, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {RA, YA, GA} = C_R; {RB, YB, GB} = C_R;
    Emg_A = 0; Emg_B = 0; clr_fault = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    total += 5;
    if (fault !== 1'b0)      begin bad++; $display("FAIL reset_fault got=%0b exp=0", fault); end
    if (fault_code !== 3'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", fault_code); end
    if (fault_dir !== 2'd0)  begin bad++; $display("FAIL reset_dir got=%0d exp=0", fault_dir); end
    if (fault_cnt !== 8'd0)  begin bad++; $display("FAIL reset_cnt got=%0d exp=0", fault_cnt); end
    if (flash !== 1'b0)      begin bad++; $display("FAIL reset_flash got=%0b exp=0", flash); end
    do_reset();
  endtask

  task automatic test_normal_cycle();
    logic [2:0] pa[4], pb[4];
    int         len[4];
    pa = '{C_G, C_Y, C_R, C_R}; pb = '{C_R, C_R, C_G, C_Y}; len = '{MIN_GA, YEL, MIN_GB, YEL};
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int ph = 0; ph < 4; ph++)
        for (int k = 0; k < len[ph]; k++) begin
          cycle(pa[ph], pb[ph], 0, 0, 0);
          total += 2;
          if (fault !== 1'b0)     begin bad++; $display("FAIL normal_fault r=%0d ph=%0d got=%0b exp=0", r, ph, fault); end
          if (fault_cnt !== 8'd0) begin bad++; $display("FAIL normal_cnt r=%0d ph=%0d got=%0d exp=0", r, ph, fault_cnt); end
        end
  endtask

  task automatic test_conflict();
    do_reset();
    for (int i = 0; i < 9; i++) cycle(C_G, C_R, 0, 0, 0);
    total++;
    if (fault !== 1'b0) begin bad++; $display("FAIL conflict_pre got=%0b exp=0", fault); end
    cycle(C_G, C_G, 0, 0, 0);
    total += 5;
    if (fault !== 1'b1)      begin bad++; $display("FAIL conflict_fault got=%0b exp=1", fault); end
    if (fault_code !== 3'd2) begin bad++; $display("FAIL conflict_code got=%0d exp=2", fault_code); end
    if (fault_dir !== 2'b11) begin bad++; $display("FAIL conflict_dir got=%0d exp=3", fault_dir); end
    if (flash !== 1'b1)      begin bad++; $display("FAIL conflict_flash0 got=%0b exp=1", flash); end
    if (fault_cnt !== 8'd1)  begin bad++; $display("FAIL conflict_cnt got=%0d exp=1", fault_cnt); end
    for (int i = 1; i < 8; i++) begin
      cycle(C_G, C_G, 0, 0, 0);
      total += 3;
      if (flash !== (i < 4))        begin bad++; $display("FAIL conflict_flash i=%0d got=%0b exp=%0b", i, flash, i < 4); end
      if (fault_cnt !== 8'(i + 1))  begin bad++; $display("FAIL conflict_cnt i=%0d got=%0d exp=%0d", i, fault_cnt, i + 1); end
      if (fault_code !== 3'd2)      begin bad++; $display("FAIL conflict_hold i=%0d got=%0d exp=2", i, fault_code); end
    end
    // clear coinciding with a new fault re-latches the new one
    cycle(C_RY, C_R, 0, 0, 1);
    total += 3;
    if (fault !== 1'b1)      begin bad++; $display("FAIL relatch_fault got=%0b exp=1", fault); end
    if (fault_code !== 3'd1) begin bad++; $display("FAIL relatch_code got=%0d exp=1", fault_code); end
    if (fault_dir !== 2'b01) begin bad++; $display("FAIL relatch_dir got=%0d exp=1", fault_dir); end
  endtask

  task automatic test_seq();
    do_reset();
    for (int i = 0; i < 8; i++) cycle(C_G, C_R, 0, 0, 0);
    cycle(C_R, C_R, 0, 0, 0);
    total += 3;
    if (fault !== 1'b1)      begin bad++; $display("FAIL seq_fault got=%0b exp=1", fault); end
    if (fault_code !== 3'd3) begin bad++; $display("FAIL seq_code got=%0d exp=3", fault_code); end
    if (fault_dir !== 2'b01) begin bad++; $display("FAIL seq_dir got=%0d exp=1", fault_dir); end
    do_reset();
    for (int i = 0; i < 7; i++) cycle(C_G, C_R, 0, 0, 0);
    cycle(C_G, C_R, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(C_R, C_R, 0, 0, 0);
      total++;
      if (fault !== 1'b0) begin bad++; $display("FAIL seq_emg i=%0d got=%0b exp=0", i, fault); end
    end
  endtask

  task automatic test_timing();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(C_G, C_R, 0, 0, 0);
    cycle(C_Y, C_R, 0, 0, 0);
    total += 2;
    if (fault_code !== 3'd4) begin bad++; $display("FAIL short_code got=%0d exp=4", fault_code); end
    if (fault_dir !== 2'b01) begin bad++; $display("FAIL short_dir got=%0d exp=1", fault_dir); end
    do_reset();
    for (int i = 0; i < MIN_GB; i++) cycle(C_R, C_G, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(C_R, C_Y, 0, 0, 0);
    total++;
    if (fault !== 1'b0) begin bad++; $display("FAIL yel_early got=%0b exp=0", fault); end
    cycle(C_R, C_R, 0, 0, 0);
    total += 2;
    if (fault_code !== 3'd5) begin bad++; $display("FAIL yel_code got=%0d exp=5", fault_code); end
    if (fault_dir !== 2'b10) begin bad++; $display("FAIL yel_dir got=%0d exp=2", fault_dir); end
  endtask

  task automatic test_emergency_lamp_clear();
    do_reset();
    for (int i = 0; i < MIN_GB; i++) cycle(C_R, C_G, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(C_R, C_Y, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cycle(C_R, C_R, 0, 0, 0);
      total++;
      if (fault !== 1'b0) begin bad++; $display("FAIL emg_relax i=%0d got=%0b exp=0", i, fault); end
    end
    cycle(C_RY, C_R, 0, 0, 0);
    total += 4;
    if (fault !== 1'b1)      begin bad++; $display("FAIL lamp_fault got=%0b exp=1", fault); end
    if (fault_code !== 3'd1) begin bad++; $display("FAIL lamp_code got=%0d exp=1", fault_code); end
    if (fault_dir !== 2'b01) begin bad++; $display("FAIL lamp_dir got=%0d exp=1", fault_dir); end
    if (fault_cnt !== 8'd1)  begin bad++; $display("FAIL lamp_cnt got=%0d exp=1", fault_cnt); end
    cycle(C_R, C_R, 0, 0, 1);
    total += 5;
    if (fault !== 1'b0)      begin bad++; $display("FAIL clr_fault got=%0b exp=0", fault); end
    if (fault_code !== 3'd0) begin bad++; $display("FAIL clr_code got=%0d exp=0", fault_code); end
    if (fault_dir !== 2'b00) begin bad++; $display("FAIL clr_dir got=%0d exp=0", fault_dir); end
    if (fault_cnt !== 8'd1)  begin bad++; $display("FAIL clr_cnt got=%0d exp=1", fault_cnt); end
    if (flash !== 1'b0)      begin bad++; $display("FAIL clr_flash got=%0b exp=0", flash); end
  endtask

  task automatic test_reset_mid_fault();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(C_G, C_G, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    {RA, YA, GA} = C_R; {RB, YB, GB} = C_R;
    model_reset();
    #1;
    total += 4;
    if (fault !== 1'b0)      begin bad++; $display("FAIL midrst_fault got=%0b exp=0", fault); end
    if (fault_code !== 3'd0) begin bad++; $display("FAIL midrst_code got=%0d exp=0", fault_code); end
    if (fault_cnt !== 8'd0)  begin bad++; $display("FAIL midrst_cnt got=%0d exp=0", fault_cnt); end
    if (flash !== 1'b0)      begin bad++; $display("FAIL midrst_flash got=%0b exp=0", flash); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(C_R, C_R, 0, 0, 0);
      total++;
      if (fault !== 1'b0) begin bad++; $display("FAIL warmup i=%0d got=%0b exp=0", i, fault); end
    end
  endtask

  task automatic test_cnt_saturate();
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      cycle(C_G, C_G, 0, 0, 0);
      if (i == 200) begin
        total++;
        if (fault_cnt !== 8'd200) begin bad++; $display("FAIL cnt_200 got=%0d exp=200", fault_cnt); end
      end
    end
    total++;
    if (fault_cnt !== 8'd255) begin bad++; $display("FAIL cnt_sat got=%0d exp=255", fault_cnt); end
  endtask

  task automatic test_random();
    int         col[2];
    logic [2:0] pat[2];
    int         roll;
    bit         ea, eb, clr;
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      col[0] = 2; col[1] = 0;
      for (int n = 0; n < 200; n++) begin
        for (int d = 0; d < 2; d++) begin
          roll = int'($urandom_range(0, 99));
          if (roll < 80)      ;
          else if (roll < 94) col[d] = succ(col[d]);
          else if (roll < 97) col[d] = int'($urandom_range(0, 2));
          pat[d] = (col[d] == 0) ? C_R : (col[d] == 1) ? C_Y : C_G;
          if (roll >= 97) pat[d] = 3'($urandom_range(0, 7));
        end
        ea  = ($urandom_range(0, 9) == 0);
        eb  = ($urandom_range(0, 9) == 0);
        clr = ($urandom_range(0, 15) == 0);
        cycle(pat[0], pat[1], ea, eb, clr);
        total += 5;
        if (fault !== m_fault)           begin bad++; $display("FAIL rnd_fault b=%0d n=%0d got=%0b exp=%0b", blk, n, fault, m_fault); end
        if (fault_code !== 3'(m_code))   begin bad++; $display("FAIL rnd_code b=%0d n=%0d got=%0d exp=%0d", blk, n, fault_code, m_code); end
        if (fault_dir !== 2'(m_dir))     begin bad++; $display("FAIL rnd_dir b=%0d n=%0d got=%0d exp=%0d", blk, n, fault_dir, m_dir); end
        if (fault_cnt !== 8'(m_cnt))     begin bad++; $display("FAIL rnd_cnt b=%0d n=%0d got=%0d exp=%0d", blk, n, fault_cnt, m_cnt); end
        if (flash !== m_flash())         begin bad++; $display("FAIL rnd_flash b=%0d n=%0d got=%0b exp=%0b", blk, n, flash, m_flash()); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_normal_cycle();
    test_conflict();
    test_seq();
    test_timing();
    test_emergency_lamp_clear();
    test_reset_mid_fault();
    test_cnt_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
